acc_requant_drain: RTL
======================

Name: acc_requant_drain

Overview:
Consumer end of the MAC array's accumulator interface. On start, it snapshots NUM_ACC signed 32-bit accumulators plus per-channel bias and issues a one-cycle clear back to the MACs. It then requantizes each channel to signed INT8 through a 2-stage pipeline: bias add, scale multiply, rounding shift, optional ReLU, saturate. Results stream out over a valid/ready port to the activation buffer writer.

Parameters:
NUM_ACC, 8, number of accumulator channels drained per start
ACC_W, 32, accumulator/bias width (signed)
SCALE_W, 16, requant multiplier width (unsigned)
SHIFT_W, 5, right-shift amount width
OUT_W, 8, output width (signed)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  begin drain; sampled only in IDLE
acc_vec  in  NUM_ACC*ACC_W  packed accumulators, channel 0 in LSBs
bias_vec  in  NUM_ACC*ACC_W  packed per-channel bias
scale  in  SCALE_W  unsigned multiplier, sampled with start
shift  in  SHIFT_W  right shift 0..31, sampled with start
relu_en  in  1  clamp negatives to 0, sampled with start
mac_clr  out  1  one-cycle pulse to MAC clr inputs
busy  out  1  high from the start-accept cycle until the done pulse
done  out  1  one-cycle pulse after the last output handshake
out_valid  out  1  output data valid
out_ready  in  1  downstream ready
out_data  out  OUT_W  requantized signed result
out_idx  out  $clog2(NUM_ACC)  channel index of out_data
out_last  out  1  high with the channel NUM_ACC-1 beat

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, the index counter is 0, and the pipeline valid bits are cleared. Reset mid-drain discards all in-flight data with no done pulse.
- FSM states:
  - IDLE -> CAPTURE when start=1.
  - CAPTURE (1 cycle): acc_vec, bias_vec, scale, shift and relu_en are already registered from the start cycle; mac_clr=1 in this cycle -> DRAIN.
  - DRAIN: issues channels 0..NUM_ACC-1 into the pipeline -> FLUSH after the last issue.
  - FLUSH: waits for the last handshake -> DONE.
  - DONE (1 cycle): done=1 -> IDLE.
- start is ignored while busy.
- Stage 1: sum = acc + bias at 33 bits signed (no overflow); prod = sum * {0,scale} at 50 bits signed.
- Stage 2, when shift>0: r = (prod + (1 << (shift-1))) >>> shift, i.e. round half toward +inf. When shift=0: r = prod.
- Stage 2, ReLU: if relu_en and r<0, then r=0.
- Stage 2, saturate: clamp r to [-128, 127].
- Output register holds out_data/out_idx/out_last/out_valid. A handshake is out_valid & out_ready.
- Pipeline advance = !out_valid | out_ready. Every stage, including the issue counter, stalls on !advance.
- Data and index stay stable while out_valid=1 and out_ready=0.
- Latency, with no backpressure: start sampled at edge 0; first out_valid at edge 3; one beat per cycle thereafter; done asserted in the cycle after the last handshake.
- The snapshot is independent of the MACs after capture, so the MACs may re-accumulate during DRAIN.

Optional Feature:
- Macro: ACC_REQUANT_SAT_CNT_EN.
- Defined: adds output port sat_cnt [15:0], counting outputs clamped by the saturation step (not the ReLU step). It clears on the start-accept cycle, saturates at 16'hFFFF, and holds after done until the next start. Reset value is 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package requant_pkg: ACC_W/OUT_W/SCALE_W/SHIFT_W defaults; OUT_MAX=127, OUT_MIN=-128; FSM state enum (IDLE, CAPTURE, DRAIN, FLUSH, DONE).
- Sub-module requant_core: the 2-stage datapath with valid/advance inputs, instantiated once.
- FSM, snapshot registers and output register stay in the top.

Test Plan:
- NUM_ACC=8, acc=1004, bias=0, scale=1, shift=3 -> out_data=126 on every idx 0..7; out_last only on idx 7; done one cycle after the 8th handshake; mac_clr pulses exactly once.
- acc=-10, bias=0, scale=1, shift=2 -> -2. acc=-12 -> -3. acc=100000, shift=0 -> 127. acc=-100000 -> -128.
- acc=-500, bias=0, scale=3, shift=1, relu_en=1 -> 0. Same with relu_en=0 -> -128. acc=40, bias=-8, scale=5, shift=4 -> 10.
- out_ready low for 5 cycles on idx 2 -> out_data/out_idx held stable. No beat is lost or duplicated; 8 beats total, in order.
- start pulsed again during DRAIN -> ignored, no extra mac_clr. rst asserted after idx 3 -> all outputs 0 next cycle, no done. A new start afterwards drains all 8 channels correctly.
- With ACC_REQUANT_SAT_CNT_EN: 3 of 8 channels saturating -> sat_cnt=3 after done, cleared to 0 on the next start.

Source files
------------

// File: rtl/acc_requant_drain_pkg.sv
// Shared constants and FSM encoding for the accumulator drain / requantizer.
package requant_pkg;

    localparam int DEF_ACC_W   = 32;
    localparam int DEF_SCALE_W = 16;
    localparam int DEF_SHIFT_W = 5;
    localparam int DEF_OUT_W   = 8;

    localparam int OUT_MAX = 127;
    localparam int OUT_MIN = -128;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        DRAIN,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/acc_requant_drain_core.sv
// Two-stage requant datapath: bias add and scale multiply, then rounding shift,
// optional ReLU and INT8 saturation. The whole pipe stalls when advance is low.
module requant_core
    import requant_pkg::*;
#(
    parameter int ACC_W   = DEF_ACC_W,
    parameter int SCALE_W = DEF_SCALE_W,
    parameter int SHIFT_W = DEF_SHIFT_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               advance,
    input  logic               in_vld,
    input  logic [ACC_W-1:0]   in_acc,
    input  logic [ACC_W-1:0]   in_bias,
    input  logic [SCALE_W-1:0] in_scale,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic               in_relu,
    input  logic [IDX_W-1:0]   in_idx,
    input  logic               in_last,
    output logic               res_vld,
    output logic [OUT_W-1:0]   res_data,
    output logic [IDX_W-1:0]   res_idx,
    output logic               res_last,
    output logic               res_sat
);

    localparam int PROD_W = ACC_W + SCALE_W + 2;
    localparam logic signed [PROD_W-1:0] MAXV = PROD_W'(OUT_MAX);
    localparam logic signed [PROD_W-1:0] MINV = PROD_W'(OUT_MIN);

    function automatic logic signed [PROD_W-1:0] round_shift(
        input logic signed [PROD_W-1:0] v,
        input logic [SHIFT_W-1:0]       sh
    );
        logic signed [PROD_W-1:0] half;
        half = '0;
        if (sh == '0) begin
            round_shift = v;
        end else begin
            half[sh - 1'b1] = 1'b1;
            round_shift = (v + half) >>> sh;
        end
    endfunction

    function automatic logic [OUT_W-1:0] saturate(input logic signed [PROD_W-1:0] v);
        if (v > MAXV)
            saturate = MAXV[OUT_W-1:0];
        else if (v < MINV)
            saturate = MINV[OUT_W-1:0];
        else
            saturate = v[OUT_W-1:0];
    endfunction

    logic [ACC_W:0]             sum;
    logic signed [PROD_W-1:0]   prod;
    logic signed [PROD_W-1:0]   prod_p1;
    logic [SHIFT_W-1:0]         shift_p1;
    logic                       relu_p1;
    logic [IDX_W-1:0]           idx_p1;
    logic                       last_p1;
    logic                       vld_p1;
    logic signed [PROD_W-1:0]   r;

    // Sign-extending to 33 bits keeps the bias add exact; scale is unsigned.
    assign sum  = {in_acc[ACC_W-1], in_acc} + {in_bias[ACC_W-1], in_bias};
    assign prod = PROD_W'($signed(sum)) * PROD_W'($signed({1'b0, in_scale}));

    // Stage 1 boundary
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (advance)
            vld_p1 <= in_vld;
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            prod_p1  <= prod;
            shift_p1 <= in_shift;
            relu_p1  <= in_relu;
            idx_p1   <= in_idx;
            last_p1  <= in_last;
        end
    end

    // Stage 2 is combinational; the top's output register closes it.
    always_comb begin
        r = round_shift(prod_p1, shift_p1);
        if (relu_p1 && (r < 0))
            r = '0;
        res_sat  = (r > MAXV) || (r < MINV);
        res_data = saturate(r);
    end

    assign res_vld  = vld_p1;
    assign res_idx  = idx_p1;
    assign res_last = last_p1;

endmodule

// File: rtl/acc_requant_drain.sv
// Accumulator drain: snapshot, clear MACs, requantize each channel to INT8 and stream out.
// Optional saturation counter port sat_cnt enabled by ACC_REQUANT_SAT_CNT_EN.
module acc_requant_drain
    import requant_pkg::*;
#(
    parameter int NUM_ACC = 8,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int SCALE_W = DEF_SCALE_W,
    parameter int SHIFT_W = DEF_SHIFT_W,
    parameter int OUT_W   = DEF_OUT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_ACC*ACC_W-1:0]   acc_vec,
    input  logic [NUM_ACC*ACC_W-1:0]   bias_vec,
    input  logic [SCALE_W-1:0]         scale,
    input  logic [SHIFT_W-1:0]         shift,
    input  logic                       relu_en,
    output logic                       mac_clr,
    output logic                       busy,
    output logic                       done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [$clog2(NUM_ACC)-1:0] out_idx,
    output logic                       out_last
`ifdef ACC_REQUANT_SAT_CNT_EN
    ,
    output logic [15:0]                sat_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_ACC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACC - 1);

    state_t state, state_nx;

    logic [NUM_ACC*ACC_W-1:0] acc_snap;
    logic [NUM_ACC*ACC_W-1:0] bias_snap;
    logic [SCALE_W-1:0]       scale_snap;
    logic [SHIFT_W-1:0]       shift_snap;
    logic                     relu_snap;
    logic [IDX_W-1:0]         idx;
    logic [ACC_W-1:0]         acc_sel;
    logic [ACC_W-1:0]         bias_sel;

    logic             advance;
    logic             accept;
    logic             last_hs;
    logic             res_vld;
    logic [OUT_W-1:0] res_data;
    logic [IDX_W-1:0] res_idx;
    logic             res_last;

    assign advance = !out_valid || out_ready;
    assign accept  = (state == IDLE) && start;
    assign last_hs = out_valid && out_ready && out_last;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        mac_clr  = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nx = CAPTURE;
            end
            CAPTURE: begin
                mac_clr  = 1'b1;
                state_nx = DRAIN;
            end
            DRAIN: begin
                if (advance && (idx == LAST_IDX))
                    state_nx = FLUSH;
            end
            FLUSH: begin
                if (last_hs)
                    state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The snapshot decouples the drain from the MACs, which may re-accumulate meanwhile.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_snap   <= acc_vec;
            bias_snap  <= bias_vec;
            scale_snap <= scale;
            shift_snap <= shift;
            relu_snap  <= relu_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            idx <= '0;
        else if (state == CAPTURE)
            idx <= '0;
        else if ((state == DRAIN) && advance)
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end

    assign acc_sel  = acc_snap[idx*ACC_W +: ACC_W];
    assign bias_sel = bias_snap[idx*ACC_W +: ACC_W];

`ifdef ACC_REQUANT_SAT_CNT_EN
    logic res_sat;
`else
    logic sat_unused;
`endif

    requant_core #(
        .ACC_W   (ACC_W),
        .SCALE_W (SCALE_W),
        .SHIFT_W (SHIFT_W),
        .OUT_W   (OUT_W),
        .IDX_W   (IDX_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .advance  (advance),
        .in_vld   (state == DRAIN),
        .in_acc   (acc_sel),
        .in_bias  (bias_sel),
        .in_scale (scale_snap),
        .in_shift (shift_snap),
        .in_relu  (relu_snap),
        .in_idx   (idx),
        .in_last  (idx == LAST_IDX),
        .res_vld  (res_vld),
        .res_data (res_data),
        .res_idx  (res_idx),
        .res_last (res_last),
`ifdef ACC_REQUANT_SAT_CNT_EN
        .res_sat  (res_sat)
`else
        .res_sat  (sat_unused)
`endif
    );

    // Output register: data only loads on a valid beat so it holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (advance) begin
            out_valid <= res_vld;
            out_last  <= res_vld && res_last;
            if (res_vld) begin
                out_data <= res_data;
                out_idx  <= res_idx;
            end
        end
    end

`ifdef ACC_REQUANT_SAT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            sat_cnt <= '0;
        else if (accept)
            sat_cnt <= '0;
        else if (advance && res_vld && res_sat && (sat_cnt != 16'hFFFF))
            sat_cnt <= sat_cnt + 16'd1;
    end
`endif

endmodule
